// File: rtl/uart_fifo_bridge.sv
// Byte FIFO bridge between a CPU/bus port and a uart core's 32-bit data register port.
// Optional registered interrupt output enabled by defining UART_FIFO_IRQ_EN.
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2    = 4,
  parameter int RX_IRQ_THRESH = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                tx_we,
  input  logic [7:0]          tx_di,
  input  logic                tx_flush,
  output logic                tx_full,
  output logic [DEPTH_LOG2:0] tx_level,
  input  logic                rx_re,
  output logic [7:0]          rx_do,
  input  logic                rx_flush,
  output logic                rx_empty,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic                rx_ovf,
  output logic                uart_data_we,
  output logic [31:0]         uart_data_di,
  input  logic                uart_data_wait,
  output logic                uart_data_re,
  input  logic [31:0]         uart_data_do,
  output logic                irq
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  // An unusable threshold leaves this named marker block in the elaborated hierarchy.
  if (RX_IRQ_THRESH < 1 || RX_IRQ_THRESH > DEPTH) begin : g_rx_irq_thresh_out_of_range
  end

  logic [7:0]            r_tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
  logic [DEPTH_LOG2:0]   r_tx_level;
  logic                  w_tx_empty, w_tx_push, w_tx_pop;

  assign w_tx_empty   = (r_tx_level == '0);
  assign tx_full      = (r_tx_level == LVL_FULL);
  assign tx_level     = r_tx_level;
  assign w_tx_push    = tx_we && !tx_full;
  assign w_tx_pop     = !w_tx_empty && !uart_data_wait;
  assign uart_data_we = !w_tx_empty;
  assign uart_data_di = {24'h0, r_tx_mem[r_tx_rd_ptr]};

  // NOTE: storage arrays are left unreset; pointers and level alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= tx_di;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn || tx_flush) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_level  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_level <= r_tx_level + LVL_ONE;
        2'b01:   r_tx_level <= r_tx_level - LVL_ONE;
        default: ;
      endcase
    end
  end

  logic [7:0]            r_rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
  logic [DEPTH_LOG2:0]   r_rx_level;
  logic                  r_rx_ovf, r_rx_held;
  logic [31:0]           r_rx_held_data;
  logic                  w_rx_full, w_rx_valid, w_rx_push, w_rx_pop;

  assign w_rx_full    = (r_rx_level == LVL_FULL);
  assign rx_empty     = (r_rx_level == '0);
  assign rx_level     = r_rx_level;
  assign rx_ovf       = r_rx_ovf;
  assign w_rx_valid   = !uart_data_do[31];
  assign uart_data_re = w_rx_valid && !w_rx_full && !rx_flush;
  assign w_rx_push    = uart_data_re;
  assign w_rx_pop     = rx_re && !rx_empty;
  assign rx_do        = rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= uart_data_do[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn || rx_flush) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_level  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_level <= r_rx_level + LVL_ONE;
        2'b01:   r_rx_level <= r_rx_level - LVL_ONE;
        default: ;
      endcase
    end
  end

  // A byte held back by a full FIFO that changes value has been overwritten inside the uart.
  always_ff @(posedge clk) begin
    if (!resetn || rx_flush) begin
      r_rx_ovf       <= 1'b0;
      r_rx_held      <= 1'b0;
      r_rx_held_data <= '0;
    end else begin
      r_rx_held      <= w_rx_valid && w_rx_full;
      r_rx_held_data <= uart_data_do;
      if (r_rx_held && (uart_data_do != r_rx_held_data)) r_rx_ovf <= 1'b1;
    end
  end

`ifdef UART_FIFO_IRQ_EN
  localparam logic [DEPTH_LOG2:0] IRQ_THRESH = (DEPTH_LOG2 + 1)'(RX_IRQ_THRESH);

  logic r_irq, r_tx_was_nonempty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_irq             <= 1'b0;
      r_tx_was_nonempty <= 1'b0;
    end else begin
      if (tx_flush)       r_tx_was_nonempty <= 1'b0;
      else if (w_tx_push) r_tx_was_nonempty <= 1'b1;
      r_irq <= (r_rx_level >= IRQ_THRESH) || (w_tx_empty && r_tx_was_nonempty);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge (default build, DEPTH_LOG2=4): TX burst/full/flush,
// RX fill/overrun/simultaneous push+pop, RX flush and reset behaviour.
module tb_uart_fifo_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tx_we, tx_flush, rx_re, rx_flush, uart_data_wait;
  logic [7:0]  tx_di;
  logic        tx_full, rx_empty, rx_ovf, uart_data_we, uart_data_re, irq;
  logic [4:0]  tx_level, rx_level;
  logic [7:0]  rx_do;
  logic [31:0] uart_data_di, uart_data_do;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  uart_fifo_bridge #(.DEPTH_LOG2(4), .RX_IRQ_THRESH(1)) dut (
    .clk(clk), .resetn(resetn),
    .tx_we(tx_we), .tx_di(tx_di), .tx_flush(tx_flush), .tx_full(tx_full), .tx_level(tx_level),
    .rx_re(rx_re), .rx_do(rx_do), .rx_flush(rx_flush), .rx_empty(rx_empty), .rx_level(rx_level),
    .rx_ovf(rx_ovf), .uart_data_we(uart_data_we), .uart_data_di(uart_data_di),
    .uart_data_wait(uart_data_wait), .uart_data_re(uart_data_re), .uart_data_do(uart_data_do),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; tx_we = 1'b0; tx_di = 8'h00; tx_flush = 1'b0;
    rx_re = 1'b0; rx_flush = 1'b0; uart_data_wait = 1'b0; uart_data_do = 32'hFFFF_FFFF;
    tick(); tick(); #1;
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_rx_do", 32'(rx_do), 32'd0);
    check("rst_we", 32'(uart_data_we), 32'd0);
    check("rst_re", 32'(uart_data_re), 32'd0);
    check("rst_ovf", 32'(rx_ovf), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    tick();

    // TX burst, uart stalls 9 cycles and accepts on the 10th
    uart_data_wait = 1'b1;
    tx_we = 1'b1; tx_di = 8'h41; tick();
    tx_di = 8'h42; tick();
    tx_di = 8'h43; tick();
    tx_we = 1'b0; #1;
    check("burst_level3", 32'(tx_level), 32'd3);
    check("burst_we", 32'(uart_data_we), 32'd1);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 10; k++) begin
        uart_data_wait = (k != 9);
        #1;
        check("burst_di", uart_data_di, 32'h41 + 32'(b));
        check("burst_we_held", 32'(uart_data_we), 32'd1);
        tick();
      end
      check("burst_level", 32'(tx_level), 32'd2 - 32'(b));
    end
    check("burst_drained_we", 32'(uart_data_we), 32'd0);

    // TX full: 17 writes with uart stalled
    uart_data_wait = 1'b1;
    tx_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_di = 8'h10 + 8'(i);
      tick();
    end
    check("full_after16", 32'(tx_full), 32'd1);
    check("full_level16", 32'(tx_level), 32'd16);
    tx_di = 8'hEE; tick();
    tx_we = 1'b0; #1;
    check("full_17th_level", 32'(tx_level), 32'd16);
    check("full_17th_head", uart_data_di, 32'h10);

    // tx_flush mid-burst, uart ready in the same cycle
    uart_data_wait = 1'b0; tx_flush = 1'b1; tick();
    tx_flush = 1'b0; #1;
    check("flush_we", 32'(uart_data_we), 32'd0);
    check("flush_level", 32'(tx_level), 32'd0);
    check("flush_full", 32'(tx_full), 32'd0);

    // TX latency plus simultaneous push/pop
    tx_we = 1'b1; tx_di = 8'hC1; tick(); #1;
    check("lat_we", 32'(uart_data_we), 32'd1);
    check("lat_di", uart_data_di, 32'hC1);
    tx_di = 8'hC2; tick();
    tx_we = 1'b0; #1;
    check("txpp_level", 32'(tx_level), 32'd1);
    check("txpp_di", uart_data_di, 32'hC2);
    tick(); #1;
    check("txpp_drained", 32'(tx_level), 32'd0);

    // RX single byte
    uart_data_do = 32'h0000_005A; #1;
    check("rx_re_pulse", 32'(uart_data_re), 32'd1);
    tick();
    uart_data_do = 32'hFFFF_FFFF; #1;
    check("rx_re_low", 32'(uart_data_re), 32'd0);
    check("rx_do_5a", 32'(rx_do), 32'h5A);
    check("rx_not_empty", 32'(rx_empty), 32'd0);
    rx_re = 1'b1; tick();
    rx_re = 1'b0; #1;
    check("rx_pop_empty", 32'(rx_empty), 32'd1);
    check("rx_pop_do0", 32'(rx_do), 32'd0);
    rx_re = 1'b1; tick();
    rx_re = 1'b0; #1;
    check("rx_pop_when_empty", 32'(rx_level), 32'd0);

    // RX full and overrun
    for (int i = 0; i < 16; i++) begin
      uart_data_do = 32'h80 + 32'(i);
      tick();
    end
    uart_data_do = 32'h0000_0077; #1;
    check("rxf_level16", 32'(rx_level), 32'd16);
    check("rxf_re_blocked", 32'(uart_data_re), 32'd0);
    tick(); #1;
    check("rxf_no_ovf_yet", 32'(rx_ovf), 32'd0);
    uart_data_do = 32'h0000_0078; #1;
    check("rxf_re_blocked2", 32'(uart_data_re), 32'd0);
    tick(); #1;
    check("rxf_ovf", 32'(rx_ovf), 32'd1);
    rx_re = 1'b1; #1;
    check("rxf_head80", 32'(rx_do), 32'h80);
    check("rxf_full_no_re", 32'(uart_data_re), 32'd0);
    tick();
    rx_re = 1'b0; #1;
    check("rxf_level15", 32'(rx_level), 32'd15);
    check("rxf_re_78", 32'(uart_data_re), 32'd1);
    tick();
    uart_data_do = 32'hFFFF_FFFF; #1;
    check("rxf_level16b", 32'(rx_level), 32'd16);
    rx_re = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("rxf_order", 32'(rx_do), 32'h80 + 32'(i));
      tick();
    end
    check("rxf_last78", 32'(rx_do), 32'h78);
    tick();
    rx_re = 1'b0; #1;
    check("rxf_drained", 32'(rx_empty), 32'd1);
    check("rxf_ovf_sticky", 32'(rx_ovf), 32'd1);

    // RX simultaneous push and pop at level 5
    for (int i = 0; i < 5; i++) begin
      uart_data_do = 32'hA0 + 32'(i);
      tick();
    end
    uart_data_do = 32'hFFFF_FFFF; #1;
    check("sim_level5", 32'(rx_level), 32'd5);
    rx_re = 1'b1; uart_data_do = 32'h0000_00A5; #1;
    check("sim_re", 32'(uart_data_re), 32'd1);
    tick();
    rx_re = 1'b0; uart_data_do = 32'hFFFF_FFFF; #1;
    check("sim_level_kept", 32'(rx_level), 32'd5);
    rx_re = 1'b1;
    for (int i = 1; i < 6; i++) begin
      check("sim_order", 32'(rx_do), 32'hA0 + 32'(i));
      tick();
    end
    rx_re = 1'b0; #1;
    check("sim_drained", 32'(rx_empty), 32'd1);

    // RX flush blocks the uart read and clears overrun
    uart_data_do = 32'h0000_00B0; tick();
    uart_data_do = 32'h0000_00B1; tick();
    uart_data_do = 32'h0000_0099; rx_flush = 1'b1; #1;
    check("rflush_re_blocked", 32'(uart_data_re), 32'd0);
    tick();
    rx_flush = 1'b0; uart_data_do = 32'hFFFF_FFFF; #1;
    check("rflush_level", 32'(rx_level), 32'd0);
    check("rflush_empty", 32'(rx_empty), 32'd1);
    check("rflush_ovf", 32'(rx_ovf), 32'd0);
    check("rflush_do", 32'(rx_do), 32'd0);

    // Reset with data buffered
    uart_data_wait = 1'b1; tx_we = 1'b1; tx_di = 8'hD1; tick();
    tx_we = 1'b0; uart_data_do = 32'h0000_00D2; tick();
    uart_data_do = 32'hFFFF_FFFF; #1;
    check("mid_tx_level", 32'(tx_level), 32'd1);
    check("mid_rx_level", 32'(rx_level), 32'd1);
    resetn = 1'b0; tick(); #1;
    check("mid_rst_tx_level", 32'(tx_level), 32'd0);
    check("mid_rst_we", 32'(uart_data_we), 32'd0);
    check("mid_rst_rx_empty", 32'(rx_empty), 32'd1);
    check("mid_rst_irq", 32'(irq), 32'd0);
    resetn = 1'b1; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
